pipelined_cond_sum_adder: RTL and testbench

- Parametrised, pipelined successor to the team's 8-bit combinational conditional-sum adder.
- Operand width is split into BLOCK-bit slices. Each slice precomputes its conditional sums for carry-in 0 and carry-in 1, then selects one with the carry registered by the previous stage.
- Adds add/subtract mode, signed-overflow flag and a valid/ready handshake with backpressure.
- Sits in the datapath as a streaming ALU adder core.

---
 rtl/pipelined_cond_sum_adder_if.sv | 24 ++
 rtl/pipelined_cond_sum_adder.sv | 85 ++++++++
 tb/tb_pipelined_cond_sum_adder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pipelined_cond_sum_adder_if.sv
// pipelined_cond_sum_adder_if: operand/result stream bundle for the pipelined conditional-sum adder
interface pipelined_cond_sum_adder_if #(
   parameter int WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, s, cout, ovf
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, s, cout, ovf
   );
endinterface

// File: rtl/pipelined_cond_sum_adder.sv
// pipelined_cond_sum_adder: streaming add/sub core, one BLOCK-bit conditional-sum slice per stage.
// Define COND_ADD_SAT_EN to saturate s on signed overflow.
module pipelined_cond_sum_adder #(
   parameter int WIDTH = 8,
   parameter int BLOCK = 4
) (
   input logic clk,
   input logic rst,
   pipelined_cond_sum_adder_if.slave bus
);
   localparam int NBLK = WIDTH / BLOCK;
   localparam logic [WIDTH-1:0] slice_mask = WIDTH'((1 << BLOCK) - 1);

   // Stage k holds operands plus the low k slices already resolved and the carry into slice k
   logic [NBLK-1:0]  v;
   logic [NBLK-1:0]  rc;
   logic [NBLK-1:0]  nc;
   logic [WIDTH-1:0] ra [NBLK];
   logic [WIDTH-1:0] rb [NBLK];
   logic [WIDTH-1:0] rs [NBLK];
   logic [WIDTH-1:0] ns [NBLK];
   logic [BLOCK:0]   p0 [NBLK];
   logic [BLOCK:0]   p1 [NBLK];
   logic [BLOCK:0]   sel [NBLK];
   logic             out_v;
   logic             stall;
   logic [WIDTH-1:0] s_q;
   logic [WIDTH-1:0] s_f;
   logic             cout_q;
   logic             ovf_q;
   logic             ovf_f;

   assign stall         = out_v && !bus.out_ready;
   assign bus.in_ready  = !stall;
   assign bus.out_valid = out_v;
   assign bus.s         = s_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;

   for (genvar g = 0; g < NBLK; g++) begin : g_slice
      assign p0[g]  = {1'b0, ra[g][g*BLOCK +: BLOCK]} + {1'b0, rb[g][g*BLOCK +: BLOCK]};
      assign p1[g]  = p0[g] + {{BLOCK{1'b0}}, 1'b1};
      assign sel[g] = rc[g] ? p1[g] : p0[g];
      assign ns[g]  = (rs[g] & ~(slice_mask << (g*BLOCK))) | (WIDTH'(sel[g][BLOCK-1:0]) << (g*BLOCK));
      assign nc[g]  = sel[g][BLOCK];
   end

   // Carry into the MSB is recovered as a^b^s at that bit, so ovf needs no extra carry tap
   assign ovf_f = ra[NBLK-1][WIDTH-1] ^ rb[NBLK-1][WIDTH-1] ^ ns[NBLK-1][WIDTH-1] ^ nc[NBLK-1];

`ifdef COND_ADD_SAT_EN
   assign s_f = ovf_f ? {ra[NBLK-1][WIDTH-1], {(WIDTH-1){~ra[NBLK-1][WIDTH-1]}}} : ns[NBLK-1];
`else
   assign s_f = ns[NBLK-1];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         v      <= '0;
         out_v  <= 1'b0;
         s_q    <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (!stall) begin
         v[0]  <= bus.in_valid;
         ra[0] <= bus.a;
         rb[0] <= bus.sub ? ~bus.b : bus.b;
         rs[0] <= '0;
         rc[0] <= bus.sub | bus.cin;
         for (int k = 1; k < NBLK; k++) begin
            v[k]  <= v[k-1];
            ra[k] <= ra[k-1];
            rb[k] <= rb[k-1];
            rs[k] <= ns[k-1];
            rc[k] <= nc[k-1];
         end
         out_v <= v[NBLK-1];
         if (v[NBLK-1]) begin
            s_q    <= s_f;
            cout_q <= nc[NBLK-1];
            ovf_q  <= ovf_f;
         end
      end
   end
endmodule

// File: tb/tb_pipelined_cond_sum_adder.sv
// tb_pipelined_cond_sum_adder: directed vectors for the pipelined conditional-sum adder (WIDTH=8, BLOCK=4)
module tb_pipelined_cond_sum_adder;
   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;

`ifdef COND_ADD_SAT_EN
   localparam logic [7:0] pos_ovf_s = 8'h7F;
   localparam logic [7:0] neg_ovf_s = 8'h80;
`else
   localparam logic [7:0] pos_ovf_s = 8'h80;
   localparam logic [7:0] neg_ovf_s = 8'h7F;
`endif

   pipelined_cond_sum_adder_if #(.WIDTH(8)) bus ();

   pipelined_cond_sum_adder #(.WIDTH(8), .BLOCK(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic single(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic icin, input logic isub,
                         input logic [7:0] es, input logic ec, input logic eo);
      int n;
      bus.a        = ia;
      bus.b        = ib;
      bus.cin      = icin;
      bus.sub      = isub;
      bus.in_valid = 1'b1;
      check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.out_valid && n < 8);
      check({tag, "_lat"}, 32'(n), 32'd2);
      check({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_s"}, 32'(bus.s), 32'(es));
      check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      check("rst_vld", 32'(bus.out_valid), 32'd0);
      check("rst_rdy", 32'(bus.in_ready), 32'd1);

      single("add35_2a", 8'h35, 8'h2A, 1'b0, 1'b0, 8'h5F, 1'b0, 1'b0);
      single("ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      single("ff_01_cin", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
      single("0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      single("sub10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
      single("sub05_03", 8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
      single("ovf_pos", 8'h7F, 8'h01, 1'b0, 1'b0, pos_ovf_s, 1'b0, 1'b1);
      single("ovf_neg", 8'h80, 8'h01, 1'b0, 1'b1, neg_ovf_s, 1'b1, 1'b1);
      tick();
      check("drain_vld", 32'(bus.out_valid), 32'd0);

      // Four back-to-back beats with a three-cycle downstream stall on the first result
      bus.b        = 8'h10;
      bus.cin      = 1'b0;
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         bus.a = 8'(i);
         tick();
      end
      check("str_first_vld", 32'(bus.out_valid), 32'd1);
      check("str_first_s", 32'(bus.s), 32'h11);
      bus.a         = 8'h04;
      bus.out_ready = 1'b0;
      #1;
      check("str_stall_rdy", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("str_hold_vld", 32'(bus.out_valid), 32'd1);
         check("str_hold_s", 32'(bus.s), 32'h11);
         check("str_hold_rdy", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("str_resume_rdy", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      for (int i = 2; i <= 4; i++) begin
         check("str_seq_vld", 32'(bus.out_valid), 32'd1);
         check("str_seq_s", 32'(bus.s), 32'(8'h10 + 8'(i)));
         tick();
      end
      check("str_end_vld", 32'(bus.out_valid), 32'd0);

      // Reset with two beats in flight: neither may ever emerge
      bus.in_valid = 1'b1;
      bus.a        = 8'h21;
      tick();
      bus.a = 8'h22;
      tick();
      bus.in_valid = 1'b0;
      rst          = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("rst_flush_vld", 32'(bus.out_valid), 32'd0);
         tick();
      end
      single("post_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
